// File: rtl/branch_predictor_bht_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predictor_bht_pkg
//  Brief    : Shared types, counter limits and index hash for the BHT predictor
//  Revision : 1.0 - initial release
// ============================================================================
package branch_predictor_bht_pkg;

   // Named 2-bit counter states, same meaning as the single-counter predictor
   typedef enum logic [1:0] {
      SNT = 2'd0,
      LNT = 2'd1,
      LT  = 2'd2,
      ST  = 2'd3
   } bht_state2_e;

   localparam int c_HASH_W = 32;

   function automatic int cnt_max(input int cnt_w);
      return (1 << cnt_w) - 1;
   endfunction

   function automatic int cnt_min(input int cnt_w);
      return (cnt_w > 0) ? 0 : 0;
   endfunction

   // Table index for a fetch PC; the fetch logic calls this too so both agree.
   // ghr_w = 0 selects the bimodal index, otherwise gshare.
   function automatic logic [c_HASH_W-1:0] bht_hash(
      input logic [63:0]         pc,
      input logic [c_HASH_W-1:0] ghr,
      input int                  index_w,
      input int                  ghr_w
   );
      logic [c_HASH_W-1:0] idx;
      logic [c_HASH_W-1:0] hist;
      idx  = c_HASH_W'(pc >> 2) & ((c_HASH_W'(1) << index_w) - c_HASH_W'(1));
      hist = (ghr_w == 0) ? '0
           : (ghr & ((c_HASH_W'(1) << ghr_w) - c_HASH_W'(1)));
      return idx ^ hist;
   endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predictor_bht_if.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predictor_bht_if
//  Brief    : Lookup (IF) and training (EX) signal bundle of the BHT predictor
//  Revision : 1.0 - initial release
// ============================================================================
interface branch_predictor_bht_if #(
   parameter int PC_W    = 32,
   parameter int INDEX_W = 6,
   parameter int GHR_W   = 0
);
   localparam int GHR_OUT_W = (GHR_W > 0) ? GHR_W : 1;

   logic [PC_W-1:0]      pred_pc_i;
   logic                 pred_taken_o;
   logic                 pred_strong_o;
   logic [INDEX_W-1:0]   pred_idx_o;
   logic                 upd_valid_i;
   logic [INDEX_W-1:0]   upd_idx_i;
   logic                 upd_taken_i;
   logic                 upd_mispred_i;
   logic [GHR_OUT_W-1:0] ghr_o;
   logic [15:0]          mispred_cnt_o;

   modport master (
      output pred_pc_i, upd_valid_i, upd_idx_i, upd_taken_i, upd_mispred_i,
      input  pred_taken_o, pred_strong_o, pred_idx_o, ghr_o, mispred_cnt_o
   );

   modport slave (
      input  pred_pc_i, upd_valid_i, upd_idx_i, upd_taken_i, upd_mispred_i,
      output pred_taken_o, pred_strong_o, pred_idx_o, ghr_o, mispred_cnt_o
   );
endinterface
`default_nettype wire

// File: rtl/branch_predictor_bht_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : bht_sat_counter
//  Brief    : One BHT entry: CNT_W-bit up/down counter saturating at both ends
//  Revision : 1.0 - initial release
// ============================================================================
module bht_sat_counter
   import branch_predictor_bht_pkg::*;
#(
   parameter int CNT_W    = 2,
   parameter int INIT_CNT = 1
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             en,
   input  wire logic             inc,
   output logic [CNT_W-1:0]      cnt
);
   localparam logic [CNT_W-1:0] c_MAX  = CNT_W'(cnt_max(CNT_W));
   localparam logic [CNT_W-1:0] c_MIN  = CNT_W'(cnt_min(CNT_W));
   localparam logic [CNT_W-1:0] c_INIT = CNT_W'(INIT_CNT);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= c_INIT;
      end else if (en) begin
         if (inc && (r_cnt != c_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end else if (!inc && (r_cnt != c_MIN)) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
      end
   end

   assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/branch_predictor_bht.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predictor_bht
//  Brief    : Flop-based BHT of saturating counters, bimodal or gshare indexed
//  Revision : 1.0 - initial release
// ============================================================================
module branch_predictor_bht
   import branch_predictor_bht_pkg::*;
#(
   parameter int PC_W     = 32,
   parameter int INDEX_W  = 6,
   parameter int CNT_W    = 2,
   parameter int GHR_W    = 0,
   parameter int INIT_CNT = (1 << (CNT_W - 1)) - 1
) (
   input  wire logic               clk,
   input  wire logic               reset,
   branch_predictor_bht_if.slave   bus
);
   localparam int               c_ENTRIES   = 1 << INDEX_W;
   localparam int               c_GHR_OUT_W = (GHR_W > 0) ? GHR_W : 1;
   localparam logic [CNT_W-1:0] c_CNT_MAX   = CNT_W'(cnt_max(CNT_W));
   localparam logic [CNT_W-1:0] c_CNT_MIN   = CNT_W'(cnt_min(CNT_W));

   logic [CNT_W-1:0]       w_cnt [c_ENTRIES];
   logic [c_GHR_OUT_W-1:0] w_ghr;
   logic [c_HASH_W-1:0]    w_hash;
   logic [c_HASH_W-1:0]    w_unused_hash;
   logic [INDEX_W-1:0]     w_pred_idx;
   logic [CNT_W-1:0]       w_sel;
   logic [15:0]            r_mispred_cnt;

   // ---------------------------------------------------------------- table
   generate
      for (genvar g = 0; g < c_ENTRIES; g++) begin : g_entry
         bht_sat_counter #(
            .CNT_W    (CNT_W),
            .INIT_CNT (INIT_CNT)
         ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .en    (bus.upd_valid_i && (bus.upd_idx_i == INDEX_W'(g))),
            .inc   (bus.upd_taken_i),
            .cnt   (w_cnt[g])
         );
      end
   endgenerate

   // ------------------------------------------------------------------ GHR
   // Non-speculative history: shifted only by resolved branches.
   generate
      if (GHR_W == 0) begin : g_bimodal
         assign w_ghr = '0;
      end else if (GHR_W == 1) begin : g_ghr_single
         logic r_ghr;
         always_ff @(posedge clk) begin
            if (reset) begin
               r_ghr <= 1'b0;
            end else if (bus.upd_valid_i) begin
               r_ghr <= bus.upd_taken_i;
            end
         end
         assign w_ghr = r_ghr;
      end else begin : g_ghr_shift
         logic [GHR_W-1:0] r_ghr;
         always_ff @(posedge clk) begin
            if (reset) begin
               r_ghr <= '0;
            end else if (bus.upd_valid_i) begin
               r_ghr <= {r_ghr[GHR_W-2:0], bus.upd_taken_i};
            end
         end
         assign w_ghr = r_ghr;
      end
   endgenerate

   // --------------------------------------------------------------- lookup
   always_comb begin
      w_hash        = bht_hash(64'(bus.pred_pc_i), c_HASH_W'(w_ghr), INDEX_W, GHR_W);
      w_pred_idx    = w_hash[INDEX_W-1:0];
      w_unused_hash = w_hash;
   end

   // Reads the registered table, so a same-cycle update is not visible yet
   assign w_sel             = w_cnt[w_pred_idx];
   assign bus.pred_idx_o    = w_pred_idx;
   assign bus.pred_taken_o  = w_sel[CNT_W-1];
   assign bus.pred_strong_o = (w_sel == c_CNT_MIN) || (w_sel == c_CNT_MAX);
   assign bus.ghr_o         = w_ghr;

   // ----------------------------------------------------------- statistics
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mispred_cnt <= '0;
      end else if (bus.upd_valid_i && bus.upd_mispred_i && (r_mispred_cnt != 16'hFFFF)) begin
         r_mispred_cnt <= r_mispred_cnt + 16'd1;
      end
   end

   assign bus.mispred_cnt_o = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_bht.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_predictor_bht
//  Brief    : Directed bench for a bimodal and a 4-bit gshare BHT instance
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_bht;
   import branch_predictor_bht_pkg::*;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   branch_predictor_bht_if #(.PC_W(32), .INDEX_W(6), .GHR_W(0)) if_b ();
   branch_predictor_bht_if #(.PC_W(32), .INDEX_W(6), .GHR_W(4)) if_g ();

   branch_predictor_bht #(.PC_W(32), .INDEX_W(6), .CNT_W(2), .GHR_W(0)) u_bim (
      .clk   (clk),
      .reset (reset),
      .bus   (if_b.slave)
   );

   branch_predictor_bht #(.PC_W(32), .INDEX_W(6), .CNT_W(2), .GHR_W(4)) u_gs (
      .clk   (clk),
      .reset (reset),
      .bus   (if_g.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic upd_b(input logic [5:0] idx, input logic taken, input logic mis);
      if_b.upd_valid_i   = 1'b1;
      if_b.upd_idx_i     = idx;
      if_b.upd_taken_i   = taken;
      if_b.upd_mispred_i = mis;
      tick();
      if_b.upd_valid_i   = 1'b0;
   endtask

   task automatic upd_g(input logic [5:0] idx, input logic taken);
      if_g.upd_valid_i   = 1'b1;
      if_g.upd_idx_i     = idx;
      if_g.upd_taken_i   = taken;
      if_g.upd_mispred_i = 1'b0;
      tick();
      if_g.upd_valid_i   = 1'b0;
   endtask

   // Expected counter walk for idx 3 under five taken updates from 1
   logic [4:0] exp_strong_walk;

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      if_b.pred_pc_i = '0; if_b.upd_valid_i = 1'b0; if_b.upd_idx_i = '0;
      if_b.upd_taken_i = 1'b0; if_b.upd_mispred_i = 1'b0;
      if_g.pred_pc_i = '0; if_g.upd_valid_i = 1'b0; if_g.upd_idx_i = '0;
      if_g.upd_taken_i = 1'b0; if_g.upd_mispred_i = 1'b0;

      // Reset and default sweep over every index
      tick();
      reset = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if_b.pred_pc_i = 32'(i) << 2;
         #1;
         check($sformatf("rst_taken[%0d]", i), {31'd0, if_b.pred_taken_o}, 32'd0);
         check($sformatf("rst_strong[%0d]", i), {31'd0, if_b.pred_strong_o}, 32'd0);
         check($sformatf("rst_idx[%0d]", i), {26'd0, if_b.pred_idx_o}, 32'(i));
      end
      check("rst_mispred", {16'd0, if_b.mispred_cnt_o}, 32'd0);
      check("rst_ghr_bim", {31'd0, if_b.ghr_o}, 32'd0);
      check("rst_ghr_gs", {28'd0, if_g.ghr_o}, 32'd0);

      // Saturate idx 3 upward: counter 2,3,3,3,3
      if_b.pred_pc_i = 32'h0000_000C;
      exp_strong_walk = 5'b11110;
      for (int k = 0; k < 5; k++) begin
         upd_b(6'd3, 1'b1, 1'b0);
         check($sformatf("sat_up_taken[%0d]", k), {31'd0, if_b.pred_taken_o}, 32'd1);
         check($sformatf("sat_up_strong[%0d]", k), {31'd0, if_b.pred_strong_o},
               {31'd0, exp_strong_walk[k]});
      end
      upd_b(6'd3, 1'b0, 1'b0);
      check("dn1_taken", {31'd0, if_b.pred_taken_o}, 32'd1);
      check("dn1_strong", {31'd0, if_b.pred_strong_o}, 32'd0);
      upd_b(6'd3, 1'b0, 1'b0);
      check("dn2_taken", {31'd0, if_b.pred_taken_o}, 32'd0);
      check("dn2_strong", {31'd0, if_b.pred_strong_o}, 32'd0);
      check("train_no_mispred", {16'd0, if_b.mispred_cnt_o}, 32'd0);

      // Same-cycle lookup and update of idx 3 (counter 1)
      if_b.upd_valid_i = 1'b1; if_b.upd_idx_i = 6'd3; if_b.upd_taken_i = 1'b1;
      #1;
      check("coll_pre", {31'd0, if_b.pred_taken_o}, 32'd0);
      tick();
      if_b.upd_valid_i = 1'b0;
      check("coll_post", {31'd0, if_b.pred_taken_o}, 32'd1);

      // Gshare history T,T,N,T
      upd_g(6'd0, 1'b1);
      check("ghr_1", {28'd0, if_g.ghr_o}, 32'b0001);
      upd_g(6'd0, 1'b1);
      check("ghr_2", {28'd0, if_g.ghr_o}, 32'b0011);
      upd_g(6'd0, 1'b0);
      check("ghr_3", {28'd0, if_g.ghr_o}, 32'b0110);
      upd_g(6'd0, 1'b1);
      check("ghr_4", {28'd0, if_g.ghr_o}, 32'b1101);
      if_g.pred_pc_i = 32'h0000_0040;
      #1;
      check("gs_idx", {26'd0, if_g.pred_idx_o}, 32'd29);
      if_b.pred_pc_i = 32'h0000_0040;
      #1;
      check("bim_idx", {26'd0, if_b.pred_idx_o}, 32'd16);
      check("bim_ghr_tied", {31'd0, if_b.ghr_o}, 32'd0);

      // Statistics: invalid updates never count, valid ones saturate
      if_b.upd_valid_i = 1'b0; if_b.upd_mispred_i = 1'b1;
      tick(); tick();
      check("stat_invalid", {16'd0, if_b.mispred_cnt_o}, 32'd0);
      for (int k = 0; k < 3; k++) upd_b(6'd10, 1'b1, 1'b1);
      check("stat_3", {16'd0, if_b.mispred_cnt_o}, 32'd3);
      if_b.upd_valid_i = 1'b1;
      for (int k = 0; k < 65532; k++) tick();
      check("stat_65535", {16'd0, if_b.mispred_cnt_o}, 32'hFFFF);
      tick(); tick();
      check("stat_sat", {16'd0, if_b.mispred_cnt_o}, 32'hFFFF);
      if_b.upd_valid_i = 1'b0;
      tick();
      check("stat_hold", {16'd0, if_b.mispred_cnt_o}, 32'hFFFF);
      if_b.upd_mispred_i = 1'b0;

      // Train idx 7 to strongly taken, then reset against a concurrent update
      if_b.pred_pc_i = 32'h0000_001C;
      for (int k = 0; k < 3; k++) upd_b(6'd7, 1'b1, 1'b0);
      check("pre_rst_taken", {31'd0, if_b.pred_taken_o}, 32'd1);
      check("pre_rst_strong", {31'd0, if_b.pred_strong_o}, 32'd1);
      reset = 1'b1;
      if_b.upd_valid_i = 1'b1; if_b.upd_idx_i = 6'd7; if_b.upd_taken_i = 1'b1;
      if_b.upd_mispred_i = 1'b1;
      if_g.upd_valid_i = 1'b1; if_g.upd_idx_i = 6'd0; if_g.upd_taken_i = 1'b1;
      tick();
      reset = 1'b0;
      if_b.upd_valid_i = 1'b0; if_b.upd_mispred_i = 1'b0;
      if_g.upd_valid_i = 1'b0;
      #1;
      check("mid_rst_taken", {31'd0, if_b.pred_taken_o}, 32'd0);
      check("mid_rst_strong", {31'd0, if_b.pred_strong_o}, 32'd0);
      check("mid_rst_mispred", {16'd0, if_b.mispred_cnt_o}, 32'd0);
      check("mid_rst_ghr", {28'd0, if_g.ghr_o}, 32'd0);
      // INIT_CNT=1: a single taken update must flip the prediction
      upd_b(6'd7, 1'b1, 1'b0);
      check("post_rst_inc", {31'd0, if_b.pred_taken_o}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
